trace_collector: RTL

TRACE_COLLECTOR -- requirements
Module: trace_collector

---
 rtl/trace_collector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/trace_collector.sv
// Trace collector: captures register-file and data-memory write events from a CPU
// into a small FIFO and tracks run/drain/halt/timeout status of the traced program.
module trace_collector #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT     = 10000,
    parameter int unsigned HALT_REPEAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wd,
    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wd,
    input  logic [31:0] pc_f,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_pc,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [31:0] cycles,
    output logic [1:0]  state,
    output logic        overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HALT_W = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [HALT_W-1:0] HALT_C  = HALT_W'(HALT_REPEAT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALT    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              mem_kind [DEPTH];
    logic [31:0]       mem_pc   [DEPTH];
    logic [31:0]       mem_addr [DEPTH];
    logic [31:0]       mem_data [DEPTH];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, dm_slot;
    logic [CNT_W-1:0]  count, count_next, free_slots;
    logic [HALT_W-1:0] halt_cnt, halt_next;
    logic [31:0]       pc_q, cycles_inc;
    logic              accept_en, run_en;
    logic              pop, grf_req, dm_req, push_grf, push_dm, drop;
    logic              pc_changed, timeout_hit;

    // A pop in the same cycle frees a slot, so a full FIFO can still take one push.
    always_comb begin
        pop        = out_valid & out_ready;
        grf_req    = accept_en & grf_we & (grf_addr != 5'd0);
        dm_req     = accept_en & dm_we;
        free_slots = DEPTH_C - count + CNT_W'(pop);
        push_grf   = grf_req & (free_slots != '0);
        push_dm    = dm_req & (push_grf ? (free_slots >= CNT_W'(2)) : (free_slots != '0));
        drop       = (grf_req & ~push_grf) | (dm_req & ~push_dm);
        dm_slot    = wr_ptr + PTR_W'(push_grf);
        count_next = count + CNT_W'(push_grf) + CNT_W'(push_dm) - CNT_W'(pop);
    end

    always_comb begin
        pc_changed  = (pc_f != pc_q);
        halt_next   = pc_changed ? '0 : ((halt_cnt == HALT_C) ? halt_cnt : halt_cnt + HALT_W'(1));
        cycles_inc  = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
        timeout_hit = (cycles_inc >= TIMEOUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Timeout beats halt detection; a PC change while draining means it was only a stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (timeout_hit)              state_d = ST_TIMEOUT;
                else if (halt_next == HALT_C) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pc_changed)                                    state_d = ST_RUN;
                else if (count == '0 && !push_grf && !push_dm)     state_d = ST_HALT;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        accept_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        run_en    = (state_q == ST_RUN);
        state     = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycles   <= '0;
            halt_cnt <= '0;
            pc_q     <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PTR_W'(push_grf) + PTR_W'(push_dm);
            rd_ptr   <= rd_ptr + PTR_W'(pop);
            count    <= count_next;
            halt_cnt <= halt_next;
            pc_q     <= pc_f;
            if (drop)   overflow <= 1'b1;
            if (run_en) cycles   <= cycles_inc;
        end
    end

    // Storage needs no reset: the head is only exposed while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (push_grf) begin
            mem_kind[wr_ptr] <= 1'b0;
            mem_pc[wr_ptr]   <= grf_pc;
            mem_addr[wr_ptr] <= {27'd0, grf_addr};
            mem_data[wr_ptr] <= grf_wd;
        end
        if (push_dm) begin
            mem_kind[dm_slot] <= 1'b1;
            mem_pc[dm_slot]   <= dm_pc;
            mem_addr[dm_slot] <= dm_addr;
            mem_data[dm_slot] <= dm_wd;
        end
    end

    always_comb begin
        out_valid = (count != '0);
        out_kind  = out_valid ? mem_kind[rd_ptr] : 1'b0;
        out_pc    = out_valid ? mem_pc[rd_ptr]   : 32'd0;
        out_addr  = out_valid ? mem_addr[rd_ptr] : 32'd0;
        out_data  = out_valid ? mem_data[rd_ptr] : 32'd0;
    end

endmodule
